// File: rtl/motor_pkg.sv
// Shared motor-drive types and helpers: FSM state encoding, PWM resolution, command clamp.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package motor_pkg;

  // Operating states of the PWM driver.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    TIMEOUT = 2'd2
  } motor_state_e;

  // PWM resolution: 512 counts per period, duty expressed in counts.
  localparam int PWM_BITS = 9;
  localparam int DUTY_MAX = 511;

  // Signed command to duty counts. Negative commands mean "no drive";
  // the signed 10-bit range tops out at 511, so positive values pass as-is.
  function automatic logic [PWM_BITS-1:0] clamp_duty(input logic signed [PWM_BITS:0] cmd);
    if (cmd[PWM_BITS]) begin
      return '0;
    end
    return cmd[PWM_BITS-1:0];
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, 9-bit period counter, period boundary and period_start.
// Latency: boundary is combinational in the last clk of a period; counters restart at 0 after it.
// Backpressure: none; counters free-run while run=1 and are held at 0 while run=0.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   run            advance counters (0 holds both counters at 0)
//   pwm_cnt        current PWM count 0..511
//   boundary       high in the clk whose edge wraps pwm_cnt 511->0
//   period_start   high in the first clk of each period (pwm_cnt=0, prescaler=0)
module pwm_timebase
  import motor_pkg::*;
#(
  parameter int PRESCALE = 98
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                boundary,
  output logic                period_start
);

  localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(DUTY_MAX);

  logic [PRE_W-1:0] pre_q;
  logic             tick;

  assign tick         = run && (pre_q == PRE_LAST);
  assign boundary     = tick && (pwm_cnt == CNT_LAST);
  assign period_start = run && (pre_q == '0) && (pwm_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      pwm_cnt <= '0;
    end else if (!run) begin
      pre_q   <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_q   <= '0;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);  // wraps 511 -> 0 naturally
    end else begin
      pre_q   <= pre_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: signed duty command -> slew-limited, watchdog-guarded fixed-frequency PWM.
// Latency: command -> target 1 clk; target -> duty_active at next period boundary; pwm_out lags pwm_cnt by 1 clk.
// Backpressure: none; cmd_valid is a strobe that is always accepted outside IDLE.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   enable         0 forces IDLE (motor off, duty cleared without slewing)
//   cmd_valid      single-cycle strobe qualifying duty_cmd; also feeds the watchdog
//   duty_cmd       signed 10-bit requested duty
//   pwm_out        registered PWM waveform
//   duty_active    duty applied in the current period, 0..511
//   period_start   one-clk pulse at the first clk of each period
//   timed_out      high while the command watchdog has expired
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PRESCALE        = 98,
  parameter int SLEW_STEP       = 16,
  parameter int TIMEOUT_PERIODS = 100
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       cmd_valid,
  input  logic signed [PWM_BITS:0]   duty_cmd,
  output logic                       pwm_out,
  output logic [PWM_BITS-1:0]        duty_active,
  output logic                       period_start,
  output logic                       timed_out
);

  localparam int                  DW       = PWM_BITS + 1;
  localparam logic [DW-1:0]       SLEW     = DW'(SLEW_STEP);
  localparam logic [PWM_BITS-1:0] SLEW9    = PWM_BITS'(SLEW_STEP);
  localparam bit                  NO_LIMIT = (SLEW_STEP == 0);
  localparam logic [9:0]          WD_LIMIT = 10'(TIMEOUT_PERIODS);

  motor_state_e          state_q, state_d;
  logic [PWM_BITS-1:0]   target_q;
  logic [PWM_BITS-1:0]   active_q;
  logic [PWM_BITS-1:0]   slewed;
  logic [9:0]            wd_q;
  logic                  pwm_q;
  logic                  run;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  boundary;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .pwm_cnt      (pwm_cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // A command arriving on the boundary that would expire the watchdog keeps us in RUN.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (!cmd_valid && boundary && (wd_q >= WD_LIMIT - 10'd1)) state_d = TIMEOUT;
        TIMEOUT: if (cmd_valid) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run       = (state_q != IDLE);
    timed_out = (state_q == TIMEOUT);
  end

  // Next duty after one slew step toward target. Sums are formed one bit
  // wider so active+step can never wrap past 511 before being compared.
  always_comb begin
    slewed = active_q;
    if (target_q > active_q) begin
      if (NO_LIMIT || ({1'b0, active_q} + SLEW >= {1'b0, target_q})) begin
        slewed = target_q;
      end else begin
        slewed = active_q + SLEW9;
      end
    end else if (target_q < active_q) begin
      if (NO_LIMIT || ({1'b0, target_q} + SLEW >= {1'b0, active_q})) begin
        slewed = target_q;
      end else begin
        slewed = active_q - SLEW9;
      end
    end
  end

  // Target, applied duty, watchdog and PWM output register.
  // Leaving or sitting in IDLE clears everything at once, with no ramp-down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q <= '0;
      active_q <= '0;
      wd_q     <= '0;
      pwm_q    <= 1'b0;
    end else begin
      pwm_q <= run && (pwm_cnt < active_q);
      if ((state_q == IDLE) || (state_d == IDLE)) begin
        target_q <= '0;
        active_q <= '0;
        wd_q     <= '0;
      end else begin
        if (cmd_valid) begin
          target_q <= clamp_duty(duty_cmd);
        end else if (state_d == TIMEOUT) begin
          target_q <= '0;
        end
        // Duty only moves at the boundary, so a period is never altered mid-way.
        if (boundary) begin
          active_q <= slewed;
        end
        if (cmd_valid) begin
          wd_q <= '0;
        end else if (boundary && (wd_q != WD_LIMIT)) begin
          wd_q <= wd_q + 10'd1;
        end
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign duty_active = active_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: instance A (PRESCALE=1, SLEW_STEP=16, TIMEOUT_PERIODS=4)
// runs the ramp/watchdog/enable/reset sequences; instance B (SLEW_STEP=0) runs a clamp table.
// Each period is 512 clk; pwm_out high-count over a period equals that period's duty.
module tb_motor_pwm_driver;

  localparam int A_SLEW = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              a_enable, a_cmd_valid;
  logic signed [9:0] a_duty_cmd;
  logic              a_pwm, a_ps, a_to;
  logic [8:0]        a_duty;
  logic              b_enable, b_cmd_valid;
  logic signed [9:0] b_duty_cmd;
  logic              b_pwm, b_ps, b_to;
  logic [8:0]        b_duty;

  always #5 clk = ~clk;

  motor_pwm_driver #(.PRESCALE(1), .SLEW_STEP(A_SLEW), .TIMEOUT_PERIODS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(a_enable), .cmd_valid(a_cmd_valid),
    .duty_cmd(a_duty_cmd), .pwm_out(a_pwm), .duty_active(a_duty),
    .period_start(a_ps), .timed_out(a_to)
  );

  motor_pwm_driver #(.PRESCALE(1), .SLEW_STEP(0), .TIMEOUT_PERIODS(100)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(b_enable), .cmd_valid(b_cmd_valid),
    .duty_cmd(b_duty_cmd), .pwm_out(b_pwm), .duty_active(b_duty),
    .period_start(b_ps), .timed_out(b_to)
  );

  typedef struct { int cmd; int exp_duty; } vec_t;
  typedef struct { logic [8:0] duty; logic tmo; } exp_t;

  vec_t tbl[8];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_duty = 0;   // duty expected during the period currently being measured
  int   ramp1[7] = '{16, 32, 48, 64, 80, 96, 100};
  int   ramp2[4] = '{84, 68, 52, 48};
  int   ramp3[3] = '{32, 16, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drop_cmd(input bit sel);
    if (sel) b_cmd_valid = 1'b0;
    else     a_cmd_valid = 1'b0;
    chk(sel ? "b_timed_out_after_cmd" : "a_timed_out_after_cmd", int'(sel ? b_to : a_to), 0);
  endtask

  // Called at the negedge of a period_start cycle; walks exactly one period,
  // counts pwm_out highs, optionally strobes a command at cycle cmd_at,
  // and ends at the negedge of the next period_start cycle.
  task automatic window(input bit sel, input int cmd_at, input int cmd, output int highs);
    highs = 0;
    for (int i = 0; i < 512; i++) begin
      if ((sel ? b_pwm : a_pwm) == 1'b1) highs++;
      if (cmd_at >= 0 && i == cmd_at + 1) drop_cmd(sel);
      if (i == cmd_at) begin
        if (sel) begin b_duty_cmd = 10'(cmd); b_cmd_valid = 1'b1; end
        else     begin a_duty_cmd = 10'(cmd); a_cmd_valid = 1'b1; end
      end
      @(negedge clk);
    end
    if (cmd_at == 511) drop_cmd(sel);
    chk(sel ? "b_period_start" : "a_period_start", int'(sel ? b_ps : a_ps), 1);
  endtask

  // One period on instance A with scoreboarded expectation for the next boundary.
  task automatic step_a(input int cmd_at, input int cmd, input int exp_duty, input bit exp_tmo);
    int   highs;
    exp_t e;
    e.duty = 9'(exp_duty);
    e.tmo  = exp_tmo;
    exp_q.push_back(e);
    window(1'b0, cmd_at, cmd, highs);
    chk("a_pwm_highs", highs, last_duty);
    e = exp_q.pop_front();
    chk("a_duty_active", int'(a_duty), int'(e.duty));
    chk("a_timed_out", int'(a_to), int'(e.tmo));
    last_duty = int'(e.duty);
  endtask

  task automatic ramp_a(input int cmd, input int from, input int tgt);
    int d = from;
    while (d != tgt) begin
      if (tgt > d) d = (d + A_SLEW > tgt) ? tgt : d + A_SLEW;
      else         d = (d - A_SLEW < tgt) ? tgt : d - A_SLEW;
      step_a(100, cmd, d, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: still running at %0t, required to finish earlier", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    int highs, n;

    tbl[0] = '{100, 100};
    tbl[1] = '{-37, 0};
    tbl[2] = '{511, 511};
    tbl[3] = '{0, 0};
    tbl[4] = '{1, 1};
    tbl[5] = '{-1, 0};
    tbl[6] = '{255, 255};
    tbl[7] = '{-512, 0};

    a_enable = 1'b0; a_cmd_valid = 1'b0; a_duty_cmd = '0;
    b_enable = 1'b0; b_cmd_valid = 1'b0; b_duty_cmd = '0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pwm_out", int'(a_pwm), 0);
    chk("reset_duty_active", int'(a_duty), 0);
    chk("reset_period_start", int'(a_ps), 0);
    chk("reset_timed_out", int'(a_to), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- Instance B: clamp table, no slew limit ----
    b_enable = 1'b1;
    n = 0;
    while (b_ps !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("b_first_period_start", int'(b_ps), 1);
    for (int k = 0; k < 8; k++) begin
      window(1'b1, 200, tbl[k].cmd, highs);
      chk("b_duty_after_boundary", int'(b_duty), tbl[k].exp_duty);
      window(1'b1, -1, 0, highs);
      chk("b_pwm_highs", highs, tbl[k].exp_duty);
    end
    b_enable = 1'b0;

    // ---- A: enable, first period_start right after IDLE->RUN ----
    a_enable = 1'b1;
    chk("a_ps_in_idle", int'(a_ps), 0);
    @(negedge clk);
    chk("a_ps_first_cycle", int'(a_ps), 1);
    last_duty = 0;

    // Ramp 0 -> 100 (command refreshed every period to keep the watchdog quiet)
    foreach (ramp1[k]) step_a(100, 100, ramp1[k], 1'b0);
    step_a(100, 100, 100, 1'b0);

    // Down to 48, then a negative command clamps the target to 0
    foreach (ramp2[k]) step_a(100, 48, ramp2[k], 1'b0);
    foreach (ramp3[k]) step_a(100, -37, ramp3[k], 1'b0);
    step_a(100, -37, 0, 1'b0);

    // Watchdog: single command of 200, then silence
    step_a(100, 200, 16, 1'b0);
    step_a(-1, 0, 32, 1'b0);
    step_a(-1, 0, 48, 1'b0);
    step_a(-1, 0, 64, 1'b1);   // 4th boundary: expires, last step still toward 200
    step_a(-1, 0, 48, 1'b1);
    step_a(-1, 0, 32, 1'b1);
    step_a(100, 50, 48, 1'b0); // new command leaves TIMEOUT
    step_a(100, 50, 50, 1'b0);
    step_a(100, 50, 50, 1'b0);

    // Enable dropped mid-period at duty 200
    ramp_a(200, 50, 200);
    repeat (100) @(negedge clk);
    chk("a_pwm_before_disable", int'(a_pwm), 1);
    a_enable = 1'b0;
    @(negedge clk);
    chk("a_duty_cleared", int'(a_duty), 0);
    @(negedge clk);
    chk("a_pwm_off_2cyc", int'(a_pwm), 0);
    highs = 0; n = 0;
    repeat (600) begin
      @(negedge clk);
      if (a_pwm) highs++;
      if (a_ps) n++;
    end
    chk("a_idle_pwm_highs", highs, 0);
    chk("a_idle_period_starts", n, 0);
    a_enable = 1'b1;
    chk("a_ps_reenable_idle", int'(a_ps), 0);
    @(negedge clk);
    chk("a_ps_reenable_first", int'(a_ps), 1);
    chk("a_duty_reenable", int'(a_duty), 0);
    last_duty = 0;
    step_a(100, 200, 16, 1'b0);
    step_a(100, 64, 32, 1'b0);
    step_a(100, 64, 48, 1'b0);
    step_a(100, 64, 64, 1'b0);

    // Command coincident with the boundary: old target 64 used, new 128 next period
    step_a(511, 128, 64, 1'b0);
    step_a(100, 128, 80, 1'b0);

    // Asynchronous reset mid-period
    repeat (50) @(negedge clk);
    chk("a_pwm_before_reset", int'(a_pwm), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_pwm_out", int'(a_pwm), 0);
    chk("async_reset_duty_active", int'(a_duty), 0);
    chk("async_reset_period_start", int'(a_ps), 0);
    chk("async_reset_timed_out", int'(a_to), 0);
    a_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Consumes the signed 10-bit motor command produced by the assistance algorithm.
- Converts that command into a fixed-frequency PWM waveform for the motor controller gate input.
- Applies per-period slew limiting and a command-loss watchdog, so the motor never steps abruptly and never runs on a stale command.
- Sits between the assistance algorithm and the motor driver pin.

Parameters:
- PRESCALE, 98: clk cycles per PWM count tick. PWM period = PRESCALE*512 clk cycles (≈1 kHz at 50 MHz). Legal range 1..65535.
- SLEW_STEP, 16: maximum change of duty_active per PWM period. 0 means no limit (duty_active jumps straight to target).
- TIMEOUT_PERIODS, 100: number of PWM periods without cmd_valid before the target is forced to 0. Legal range 1..1023.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  rider/system enable; low forces the motor off
- cmd_valid  in  1  single-cycle strobe; duty_cmd is valid this cycle
- duty_cmd  in  10 signed  requested duty (assistance algorithm output)
- pwm_out  out  1  registered PWM waveform to the motor driver
- duty_active  out  9  duty currently applied, 0..511 (of 512 counts)
- period_start  out  1  one-cycle pulse on the first clk of each PWM period
- timed_out  out  1  high while in state TIMEOUT

Behaviour:
- Reset (async, reset_n low): all registers cleared. Outputs: pwm_out=0, duty_active=0, period_start=0, timed_out=0. State=IDLE.
- Command capture:
  - On a cycle with cmd_valid=1, target <= clamp(duty_cmd): negative → 0; 0..511 passed through unchanged.
  - Target is updated on the following edge (1-cycle latency).
  - cmd_valid also clears the watchdog counter.
- Counters:
  - Prescaler counts 0..PRESCALE-1. A tick fires when the prescaler equals PRESCALE-1.
  - pwm_cnt (9-bit) increments on each tick and wraps 511→0.
  - The boundary is the tick on which pwm_cnt wraps to 0. period_start is asserted for the clk cycle in which pwm_cnt=0 and prescaler=0.
- Duty update: only at the boundary, using the target value held before that edge.
  - If target>active: active <= min(target, active+SLEW_STEP).
  - If target<active: active <= max(target, active-SLEW_STEP).
  - Arithmetic is 10-bit internally so that it cannot wrap.
  - Mid-period command changes never alter the current period.
- PWM output: pwm_out <= (state!=IDLE) && (pwm_cnt < duty_active), registered with 1-cycle lag.
  - duty_active=0 → pwm_out constantly low.
  - duty_active=511 → high for 511 of 512 counts.
- State machine:
  - IDLE: counters held at 0, target=0, duty_active=0, pwm_out=0. Transitions to RUN on enable=1; pwm_cnt starts at 0, so the first period_start occurs on the cycle after the transition.
  - RUN: normal operation. At each boundary the watchdog increments, saturating at TIMEOUT_PERIODS. When it reaches TIMEOUT_PERIODS, go to TIMEOUT.
  - TIMEOUT: target forced to 0 and timed_out=1. duty_active slews down normally. cmd_valid returns to RUN (timed_out clears next cycle, target takes the new command).
  - Any state, enable=0: go to IDLE on the next edge. pwm_out is low one cycle later; duty_active and target clear immediately, with no slewing.
- Simultaneous events:
  - cmd_valid on the same cycle as the boundary: the boundary uses the old target; the new target applies at the next boundary.
  - cmd_valid on the same cycle as the watchdog reaching its limit: cmd_valid wins, the watchdog clears, and the state stays RUN.
  - enable=0 overrides everything.
- Reset mid-period: immediate return to the reset values above. No partial pulse is completed.

Decomposition:
- Shared package motor_pkg:
  - state enum {IDLE, RUN, TIMEOUT}
  - PWM_BITS=9
  - DUTY_MAX=511
  - clamp function for signed-to-duty conversion (reused by the assistance path)
- One natural sub-module: pwm_timebase, containing the prescaler, pwm_cnt, the boundary tick and period_start. Slew, watchdog and FSM stay in the top level.

Test Plan (PRESCALE=1, SLEW_STEP=16, TIMEOUT_PERIODS=4 unless noted):
1. Reset then enable=1, cmd duty_cmd=100 → duty_active goes 16,32,…,96,100 on successive boundaries (7 periods). Final period has pwm_out high for exactly 100 of 512 cycles.
2. duty_cmd=-37 while duty_active=48 → target 0; duty_active goes 32,16,0. Afterwards pwm_out is never high.
3. SLEW_STEP=0, duty_cmd=511 → next boundary duty_active=511; pwm_out low exactly 1 cycle per period.
4. cmd 200 held steady, no further cmd_valid → timed_out=1 after the 4th boundary; duty_active ramps to 0. A new cmd_valid with 50 → timed_out=0 next cycle, and the ramp ends at 50.
5. duty_active=200, enable dropped mid-period → pwm_out=0 within 2 cycles, duty_active=0. Re-enable → first period_start on the cycle after the IDLE→RUN transition, ramp restarts from 0.
6. cmd_valid coincident with the boundary (old target 64, new 128, active 64) → active stays 64 at that boundary, then 80 at the next. reset_n pulsed mid-period → all outputs 0 asynchronously.
